// File: rtl/dot_product_driver.sv
// Purpose: stream initiator for the serial dot-product unit. It latches one vector pair,
//   serializes a0..a(N-1), b0..b(N-1) onto din_out, waits for the unit's run strobe, and
//   presents the captured result downstream.
// Latency: a0 is on din_out the cycle after accept. The minimum accept-to-out_valid time
//   is 2N+1 cycles. The WAIT phase is bounded by TIMEOUT cycles.
// Backpressure: in_ready is high only in IDLE, and there is no buffering beyond one pair.
//   The result is held in HOLD until out_ready.
// Ports:
//   clk, resetn               clock and async active-low reset
//   in_valid/in_ready/in_a/in_b   vector pair input; element k = [k*DATA_W +: DATA_W]
//   din_out, frame, last      registered serial stream to the unit (frame=a0, last=b(N-1))
//   res_in, res_run           the unit's dout and run strobe (run only honoured in WAIT)
//   out_valid/out_ready/out_result   result output handshake
//   timeout, mismatch         result was forced by timeout / self-check failed
// Optional feature: define DOT_PRODUCT_DRIVER_CHECK_EN to add a local multiply-accumulate
//   that cross-checks the unit's answer; otherwise mismatch is tied to 0.
module dot_product_driver #(
  parameter int DATA_W  = 8,
  parameter int N       = 3,
  parameter int RES_W   = 18,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_a,
  input  logic [N*DATA_W-1:0]   in_b,
  output logic [DATA_W-1:0]     din_out,
  output logic                  frame,
  output logic                  last,
  input  logic [RES_W-1:0]      res_in,
  input  logic                  res_run,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RES_W-1:0]      out_result,
  output logic                  timeout,
  output logic                  mismatch
);

  localparam int IDX_W = $clog2(2 * N);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * N - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]      idx;
  logic [CNT_W-1:0]      cnt;
  // Holds {b, a}. The element currently on din_out sits in the low slot, and the
  // register shifts down by one element per SEND cycle.
  logic [2*N*DATA_W-1:0] sreg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SEND;
      end
      SEND: if (idx == LAST_IDX) state_nxt = WAIT;
      WAIT: if (res_run || cnt == CNT_LAST) state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DOT_PRODUCT_DRIVER_CHECK_EN
  logic [N*DATA_W-1:0] a_q, b_q;
  logic [RES_W-1:0]    expected;
  logic                mismatch_q;

  always_comb begin
    expected = '0;
    for (int k = 0; k < N; k++) begin
      expected = expected + (RES_W'(a_q[k*DATA_W +: DATA_W]) * RES_W'(b_q[k*DATA_W +: DATA_W]));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q        <= '0;
      b_q        <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (state == WAIT) begin
        if (res_run)              mismatch_q <= (res_in != expected);
        else if (cnt == CNT_LAST) mismatch_q <= 1'b1;
      end
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx        <= '0;
      cnt        <= '0;
      sreg       <= '0;
      din_out    <= '0;
      frame      <= 1'b0;
      last       <= 1'b0;
      out_result <= '0;
      timeout    <= 1'b0;
    end else begin
      // The stream outputs are pulses: they default to 0 and are driven only for SEND cycles.
      din_out <= '0;
      frame   <= 1'b0;
      last    <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg    <= {in_b, in_a};
            din_out <= in_a[DATA_W-1:0];
            frame   <= 1'b1;
            idx     <= '0;
          end
        end
        SEND: begin
          if (idx != LAST_IDX) begin
            idx     <= idx + IDX_W'(1);
            sreg    <= sreg >> DATA_W;
            din_out <= sreg[DATA_W +: DATA_W];
            last    <= ((idx + IDX_W'(1)) == LAST_IDX);
          end else begin
            cnt <= '0;
          end
        end
        WAIT: begin
          // A run strobe takes priority over a timeout that expires in the same cycle.
          if (res_run) begin
            out_result <= res_in;
            timeout    <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            out_result <= '0;
            timeout    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_driver.sv
// Directed bench for dot_product_driver: streaming order, latency, result capture,
// timeout, HOLD backpressure and mid-frame reset.
module tb_dot_product_driver;
  localparam int DATA_W  = 8;
  localparam int N       = 3;
  localparam int RES_W   = 18;
  localparam int TIMEOUT = 64;
`ifdef DOT_PRODUCT_DRIVER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                resetn;
  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] in_a, in_b;
  logic [DATA_W-1:0]   din_out;
  logic                frame, last;
  logic [RES_W-1:0]    res_in;
  logic                res_run;
  logic                out_valid;
  logic                out_ready;
  logic [RES_W-1:0]    out_result;
  logic                timeout;
  logic                mismatch;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dot_product_driver #(.DATA_W(DATA_W), .N(N), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .din_out(din_out), .frame(frame), .last(last),
    .res_in(res_in), .res_run(res_run),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .timeout(timeout), .mismatch(mismatch)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one pair and returns just after the accept edge (a0 on din_out).
  task automatic send_frame(input logic [N*DATA_W-1:0] a, input logic [N*DATA_W-1:0] b);
    int w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
    end
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    res_in = '0; res_run = 1'b0; out_ready = 1'b0;
    #3;
    tests++;
    if ({in_ready, out_valid, frame, last, timeout, mismatch} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_flags: rdy/vld/frm/lst/to/mm=%b required 100000",
               {in_ready, out_valid, frame, last, timeout, mismatch});
    end
    tests++;
    if (din_out !== 8'd0 || out_result !== 18'd0) begin
      fails++;
      $display("FAIL reset_data: din_out=%0d out_result=%0d required 0 0", din_out, out_result);
    end
    step(); step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [7:0] exp_d [6];
    exp_d[0] = 8'd1; exp_d[1] = 8'd2; exp_d[2] = 8'd3;
    exp_d[3] = 8'd4; exp_d[4] = 8'd5; exp_d[5] = 8'd6;
    send_frame({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4});
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (din_out !== exp_d[i] || frame !== (i == 0) || last !== (i == 5) || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stream[%0d]: din=%0d frame=%0b last=%0b rdy=%0b required din=%0d frame=%0b last=%0b rdy=0",
                 i, din_out, frame, last, in_ready, exp_d[i], (i == 0), (i == 5));
      end
      // A run strobe during SEND must be ignored.
      if (i == 1) begin res_run = 1'b1; res_in = 18'd7; end
      else res_run = 1'b0;
      step();
    end
    tests++;
    if (din_out !== 8'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_wait: din=%0d out_valid=%0b required 0 0", din_out, out_valid);
    end
    step(); step();
    res_run = 1'b1; res_in = 18'd32;
    step();
    res_run = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_result !== 18'd32 || timeout !== 1'b0 || mismatch !== 1'b0) begin
      fails++;
      $display("FAIL stream_result: vld=%0b res=%0d to=%0b mm=%0b required 1 32 0 0",
               out_valid, out_result, timeout, mismatch);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 18'd32) begin
      fails++;
      $display("FAIL stream_drain: vld=%0b rdy=%0b res=%0d required 0 1 32", out_valid, in_ready, out_result);
    end
  endtask

  task automatic test_latency();
    send_frame({8'd30, 8'd20, 8'd10}, {8'd3, 8'd2, 8'd1});
    repeat (6) step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: out_valid=%0b required 0", out_valid);
    end
    res_run = 1'b1; res_in = 18'd140;
    step();
    res_run = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_result !== 18'd140) begin
      fails++;
      $display("FAIL latency_7: vld=%0b res=%0d required 1 140", out_valid, out_result);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_check();
    send_frame({8'd255, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd255});
    repeat (6) step();
    res_run = 1'b1; res_in = 18'd195075;
    step();
    res_run = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_result !== 18'd195075 || mismatch !== 1'b0) begin
      fails++;
      $display("FAIL check_good: vld=%0b res=%0d mm=%0b required 1 195075 0", out_valid, out_result, mismatch);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    send_frame({8'd255, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd255});
    repeat (6) step();
    res_run = 1'b1; res_in = 18'd195074;
    step();
    res_run = 1'b0;
    tests++;
    if (out_result !== 18'd195074 || mismatch !== CHK) begin
      fails++;
      $display("FAIL check_bad: res=%0d mm=%0b required 195074 %0b", out_result, mismatch, CHK);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    logic [7:0] exp_d [6];
    exp_d[0] = 8'd7; exp_d[1] = 8'd8; exp_d[2] = 8'd9;
    exp_d[3] = 8'd1; exp_d[4] = 8'd1; exp_d[5] = 8'd1;
    send_frame({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4});
    repeat (3) step();
    tests++;
    if (din_out !== 8'd4) begin
      fails++;
      $display("FAIL mid_b0: din_out=%0d required 4", din_out);
    end
    #2 resetn = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, frame, last, timeout, mismatch} !== 6'b100000 ||
        din_out !== 8'd0 || out_result !== 18'd0) begin
      fails++;
      $display("FAIL mid_reset: rdy/vld/frm/lst/to/mm=%b din=%0d res=%0d required 100000 0 0",
               {in_ready, out_valid, frame, last, timeout, mismatch}, din_out, out_result);
    end
    step(); step();
    resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) seen++;
      step();
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL mid_no_result: out_valid cycles=%0d required 0", seen);
    end
    send_frame({8'd9, 8'd8, 8'd7}, {8'd1, 8'd1, 8'd1});
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (din_out !== exp_d[i] || frame !== (i == 0) || last !== (i == 5)) begin
        fails++;
        $display("FAIL restream[%0d]: din=%0d frame=%0b last=%0b required %0d %0b %0b",
                 i, din_out, frame, last, exp_d[i], (i == 0), (i == 5));
      end
      step();
    end
    res_run = 1'b1; res_in = 18'd24;
    step();
    res_run = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_result !== 18'd24 || mismatch !== 1'b0) begin
      fails++;
      $display("FAIL restream_result: vld=%0b res=%0d mm=%0b required 1 24 0", out_valid, out_result, mismatch);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_timeout_hold();
    int n = 0;
    send_frame({8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2});
    repeat (6) step();
    while (out_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    tests++;
    if (n != TIMEOUT) begin
      fails++;
      $display("FAIL timeout_cycles: waited=%0d required %0d", n, TIMEOUT);
    end
    tests++;
    if (out_result !== 18'd0 || timeout !== 1'b1 || mismatch !== CHK) begin
      fails++;
      $display("FAIL timeout_result: res=%0d to=%0b mm=%0b required 0 1 %0b", out_result, timeout, mismatch, CHK);
    end
    in_valid = 1'b1; in_a = {8'd5, 8'd5, 8'd5}; in_b = {8'd5, 8'd5, 8'd5};
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 18'd0 ||
          timeout !== 1'b1 || din_out !== 8'd0) begin
        fails++;
        $display("FAIL hold[%0d]: vld=%0b rdy=%0b res=%0d to=%0b din=%0d required 1 0 0 1 0",
                 i, out_valid, in_ready, out_result, timeout, din_out);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || timeout !== 1'b1) begin
      fails++;
      $display("FAIL hold_release: rdy=%0b vld=%0b to=%0b required 1 0 1", in_ready, out_valid, timeout);
    end
    step();
    tests++;
    if (in_ready !== 1'b1 || din_out !== 8'd0) begin
      fails++;
      $display("FAIL hold_ignored: rdy=%0b din=%0d required 1 0", in_ready, din_out);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_check();
    test_reset_mid();
    test_timeout_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dot_product_driver.md
# dot_product_driver

Stream initiator for the serial dot-product unit. Accepts two N-element unsigned vectors in parallel over a valid/ready handshake and serializes them one element per clock onto the unit's `din` input, in the order a0..a(N-1), b0..b(N-1). It then waits for the unit's `run` strobe, captures the result, and presents it downstream on a valid/ready handshake. A timeout guards against a unit that never answers.

## Interface
Parameters:
- `DATA_W`, 8, element width (unsigned).
- `N`, 3, elements per vector.
- `RES_W`, 18, result width; must be ≥ 2*DATA_W + clog2(N).
- `TIMEOUT`, 64, maximum number of WAIT cycles before the timeout fires (≥ 1).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `resetn` in 1: asynchronous active-low reset.
- `in_valid` in 1: vector pair offered.
- `in_ready` out 1: driver can accept a vector pair.
- `in_a` in N*DATA_W: vector A; element k is bits [k*DATA_W +: DATA_W].
- `in_b` in N*DATA_W: vector B; same packing as `in_a`.
- `din_out` out DATA_W: serial element to the unit's `din` (registered).
- `frame` out 1: high with element a0.
- `last` out 1: high with element b(N-1).
- `res_in` in RES_W: the unit's `dout`.
- `res_run` in 1: the unit's `run` (result valid strobe).
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts the result.
- `out_result` out RES_W: captured result.
- `timeout` out 1: the current result was produced by a timeout.
- `mismatch` out 1: self-check failure (see Configuration).

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `in_a`/`in_b`, clear the index, go to SEND.
  - SEND: drive element `idx` (0..N-1 from A, N..2N-1 from B), then increment `idx`. After element 2N-1 is driven, go to WAIT and clear the timeout counter.
  - WAIT: if `res_run`=1, capture `res_in` into `out_result`, set `timeout`=0, go to HOLD. Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no `res_run`, set `out_result`=0 and `timeout`=1, then go to HOLD.
  - HOLD: `out_valid`=1. On `out_ready`, go to IDLE.
- `res_run` is ignored outside WAIT.
- `in_ready`=0 in SEND, WAIT and HOLD. There is no input buffering beyond the single latched pair.
- `din_out` is 0 whenever the state is not SEND.
- `frame` and `last` are high only in the cycle their element is on `din_out`.
- `out_result`, `timeout` and `mismatch` hold steady throughout HOLD, and keep their last value after leaving HOLD.
- Arithmetic is unsigned and zero-extended. No saturation is needed, because RES_W covers the full range.

## Timing
- Reset (asynchronous assert, synchronous release): state is IDLE; `in_ready`=1; `din_out`, `frame`, `last`, `out_valid`, `out_result`, `timeout`, `mismatch` and all counters are 0.
- Accept occurs at edge T0. `din_out` shows a0 in the cycle after T0, then one element per cycle, so b(N-1) appears in cycle T0+2N.
- WAIT starts in cycle T0+2N+1.
- `res_run` sampled high at edge Tr causes `out_valid`=1 from Tr onward.
- Minimum accept-to-`out_valid` latency is 2N+1 cycles (7 for N=3). This is the case where `res_run` is high in the first WAIT cycle.
- The handshake completes at the edge where `out_valid`&&`out_ready`. `in_ready` is 1 in the following cycle, so back-to-back frames are separated by at least one IDLE cycle.
- Reset asserted mid-frame (any state) aborts the frame immediately. No partial result is emitted.
- `res_run` and the timeout expiring in the same WAIT cycle: the result is captured and `timeout`=0.

## Configuration
- `DOT_PRODUCT_DRIVER_CHECK_EN` defined:
  - A local multiply-accumulate computes the sum of a[k]*b[k] from the latched vectors.
  - On capture in WAIT, `mismatch` is set to (`res_in` != expected).
  - On timeout, `mismatch` is set to 1.
  - `mismatch` is valid in HOLD.
- Not defined: the local multiply-accumulate logic is absent and `mismatch` is tied to 0.

## Test plan
- Reset, then accept A=(1,2,3), B=(4,5,6). Required: `din_out`=1,2,3,4,5,6 on consecutive cycles, with `frame` on 1 and `last` on 6. The model unit returns 32; `out_result`=32, `timeout`=0, `mismatch`=0.
- Accept A=(10,20,30), B=(1,2,3) with `res_run` in the first WAIT cycle. Required: `out_valid` exactly 7 cycles after accept and `out_result`=140.
- With CHECK_EN defined, A=(255,255,255), B=(255,255,255) and the model returns 195075. Required: `out_result`=195075 and `mismatch`=0. Then return 195074 for the same vectors; required: `mismatch`=1.
- Model never asserts `res_run`, TIMEOUT=64. Required: `out_valid` rises 64 cycles after WAIT entry, with `out_result`=0 and `timeout`=1.
- Hold `out_ready` low for 5 cycles in HOLD. Required: `out_result` stable, `in_ready`=0 and any `in_valid` ignored. `in_ready`=1 the cycle after `out_ready` goes high.
- Assert `resetn` low while b0 is on `din_out`. Required: all outputs go to reset values immediately and no `out_valid` occurs. A new frame after release streams correctly from a0.
